// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select, IF/ID pipeline register,
// stall/flush/halt control. Optional redirect alignment check via PC_ALIGN_CHECK_EN.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HALT_INSTR = 32'h0000_000C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4,
  output logic [31:0] pc,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_instr,
  output logic        id_valid,
  output logic        halted,
  output logic [31:0] fetch_cnt,
  output logic        misalign
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]  state;
  logic [0:0]  state_next;
  logic [31:0] target_pc;
  logic        misalign_hit;
  logic        load_valid;
  logic        load_bubble;

`ifdef PC_ALIGN_CHECK_EN
  assign target_pc    = {redirect_pc[31:2], 2'b00};
  assign misalign_hit = redirect && (redirect_pc[1:0] != 2'b00);
`else
  assign target_pc    = redirect_pc;
  assign misalign_hit = 1'b0;
`endif

  // Priority per edge: redirect > stall > halt > normal fetch.
  assign load_valid  = !redirect && !stall && (state == ST_RUN);
  assign load_bubble = redirect || (!stall && (state == ST_HALT));

  always_comb begin
    state_next = state;
    if (redirect) begin
      state_next = ST_RUN;
    end else if (load_valid && (instr_in == HALT_INSTR)) begin
      state_next = ST_HALT;
    end
  end

  // The FSM state is observable directly: halted is the state flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  assign halted = (state == ST_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= target_pc;
    end else if (load_valid) begin
      pc <= pc_plus4;
    end
  end

  // Bubbles clear valid and instruction; id_pc fields are don't-care then and hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_pc       <= 32'h0;
      id_pc_plus4 <= 32'h0;
      id_instr    <= 32'h0;
      id_valid    <= 1'b0;
    end else if (load_bubble) begin
      id_instr    <= 32'h0;
      id_valid    <= 1'b0;
    end else if (load_valid) begin
      id_pc       <= pc;
      id_pc_plus4 <= pc_plus4;
      id_instr    <= instr_in;
      id_valid    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= 32'h0;
    end else if (load_valid) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign <= 1'b0;
    end else if (misalign_hit) begin
      misalign <= 1'b1;
    end
  end

endmodule
